// File: rtl/alu_calc_core_if.sv
// Button, operand-control and display/result bundle of the calculator core.
// The master side is the board (or a bench); the slave side is alu_calc_core.
interface alu_calc_core_if #(
    parameter int WIDTH = 16
);
    logic             bit0_btn;
    logic             bit1_btn;
    logic             dir;
    logic             clr_entry;
    logic             load_a;
    logic             load_b;
    logic [2:0]       op;
    logic             go;
    logic [1:0]       disp_sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] disp;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             flag_err;

    modport master (
        output bit0_btn, bit1_btn, dir, clr_entry, load_a, load_b, op, go, disp_sel,
        input  busy, done, disp, result, flag_z, flag_n, flag_c, flag_v, flag_err
    );

    modport slave (
        input  bit0_btn, bit1_btn, dir, clr_entry, load_a, load_b, op, go, disp_sel,
        output busy, done, disp, result, flag_z, flag_n, flag_c, flag_v, flag_err
    );
endinterface

// File: rtl/alu_calc_core.sv
// Bit-serial operand entry, A/B latches and an 8-op ALU with flags and display mux.
// Define ALU_MUL_EN to build the shift-and-add multiplier; otherwise op 111 reports ERR.
module alu_calc_core #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              hz100,
    input  logic              reset,
    alu_calc_core_if.slave    bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
    } op_t;

    logic [2:0] btn_sync, btn_prev;
    logic       p0, p1, pgo;

    logic [WIDTH-1:0] entry, a_reg, b_reg, a_s, b_s, result_q;
    op_t              op_s;
    state_t           state;
    logic             busy_q, done_q;
    logic             fz, fn, fc, fv, ferr;

    // NOTE: all sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge hz100) begin
        if (reset) begin
            btn_sync <= '0;
            btn_prev <= '0;
        end else begin
            btn_sync <= {bus.go, bus.bit1_btn, bus.bit0_btn};
            btn_prev <= btn_sync;
        end
    end

    assign p0  = btn_sync[0] & ~btn_prev[0];
    assign p1  = btn_sync[1] & ~btn_prev[1];
    assign pgo = btn_sync[2] & ~btn_prev[2];

    // A simultaneous bit0+bit1 press shifts a single 1, since the new bit is p1.
    always_ff @(posedge hz100) begin
        if (reset) begin
            entry <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (bus.clr_entry)
                entry <= '0;
            else if (p0 | p1)
                entry <= bus.dir ? {p1, entry[WIDTH-1:1]} : {entry[WIDTH-2:0], p1};
            if (bus.load_a)
                a_reg <= entry;
            else if (bus.load_b)
                b_reg <= entry;
        end
    end

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_err;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum     = {1'b0, a_s} + {1'b0, b_s};
        diff    = {1'b0, a_s} - {1'b0, b_s};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_s)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (alu_res[WIDTH-1] != a_s[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (alu_res[WIDTH-1] != a_s[WIDTH-1]);
            end
            OP_AND:  alu_res = a_s & b_s;
            OP_OR:   alu_res = a_s | b_s;
            OP_XOR:  alu_res = a_s ^ b_s;
            OP_SHL:  alu_res = a_s << b_s[SHW-1:0];
            OP_SHR:  alu_res = a_s >> b_s[SHW-1:0];
`ifdef ALU_MUL_EN
            default: alu_err = 1'b0;
`else
            default: alu_err = 1'b1;
`endif
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;

    always_comb begin
        acc_next = mplier[0] ? acc + mcand : acc;
    end
`endif

    always_ff @(posedge hz100) begin
        if (reset) begin
            state    <= ST_IDLE;
            a_s      <= '0;
            b_s      <= '0;
            op_s     <= OP_ADD;
            result_q <= '0;
            {fz, fn, fc, fv, ferr} <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (pgo) begin
                    a_s    <= a_reg;
                    b_s    <= b_reg;
                    op_s   <= op_t'(bus.op);
                    busy_q <= 1'b1;
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
`ifdef ALU_MUL_EN
                    if (op_s == OP_MUL) begin
                        acc    <= '0;
                        cnt    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a_s};
                        mplier <= b_s;
                        state  <= ST_MUL;
                    end else
`endif
                    begin
                        result_q <= alu_res;
                        fz       <= (alu_res == '0);
                        fn       <= alu_res[WIDTH-1];
                        fc       <= alu_c;
                        fv       <= alu_v;
                        ferr     <= alu_err;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        result_q <= acc_next[WIDTH-1:0];
                        fz       <= (acc_next[WIDTH-1:0] == '0);
                        fn       <= acc_next[WIDTH-1];
                        fc       <= |acc_next[2*WIDTH-1:WIDTH];
                        fv       <= 1'b0;
                        ferr     <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (bus.disp_sel)
            2'b00:   bus.disp = entry;
            2'b01:   bus.disp = a_reg;
            2'b10:   bus.disp = b_reg;
            default: bus.disp = result_q;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.flag_z   = fz;
    assign bus.flag_n   = fn;
    assign bus.flag_c   = fc;
    assign bus.flag_v   = fv;
    assign bus.flag_err = ferr;

endmodule

// File: doc/alu_calc_core.md
# alu_calc_core

Parametrised operand-entry and arithmetic core for the board calculator. It takes bit-serial operand entry from two push-buttons into a shift register and latches operands A and B. On a `go` press it executes one of eight operations: single-cycle logic/add/shift, or a multi-cycle shift-and-add multiply. It registers the result with status flags and drives one WIDTH-bit display bus for the seven-segment decoders.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; power of two, ≥4
- `SHW`, `$clog2(WIDTH)`, shift-amount width (derived; do not override)

Ports:
- `hz100`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `bit0_btn`  in  1  raw button; rising edge shifts a 0 into entry
- `bit1_btn`  in  1  raw button; rising edge shifts a 1 into entry
- `dir`  in  1  0: shift left, new bit into LSB; 1: shift right, new bit into MSB
- `clr_entry`  in  1  level; clears entry register
- `load_a`  in  1  level; A <= entry every cycle while high
- `load_b`  in  1  level; B <= entry every cycle while high (ignored if `load_a`)
- `op`  in  3  000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SHL A by B[SHW-1:0], 110 SHR (logical) A by B[SHW-1:0], 111 MUL (low WIDTH bits)
- `go`  in  1  raw button; rising edge starts an operation
- `disp_sel`  in  2  00 entry, 01 A, 10 B, 11 result
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; result/flags valid
- `disp`  out  WIDTH  display bus selected by `disp_sel` (combinational mux of registers)
- `result`  out  WIDTH  last result
- `flag_z`, `flag_n`, `flag_c`, `flag_v`, `flag_err`  out  1 each  zero, negative, carry/borrow, signed overflow, error

## Operation
- Edge detect: each of `bit0_btn`, `bit1_btn`, `go` passes through a sync flop and a prev flop. Pulse = sync & ~prev.
- Entry: one shift per cycle when either bit pulse is high. Shifted-in bit = bit1 pulse; both pulses in the same cycle shift in a single 1. `clr_entry` beats any shift.
- Loads: `load_a` beats `load_b`. Loads remain legal while busy. The running operation uses operand snapshots A_s/B_s/op_s captured on the accepted `go` pulse.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE: `go` pulse -> capture snapshots -> EXEC.
  - EXEC, op_s≠MUL: compute and register result plus flags -> DONE.
  - EXEC, op_s=MUL: clear accumulator and counter -> MUL.
  - MUL: each cycle, if multiplier LSB is 1 add multiplicand into the 2×WIDTH accumulator; shift multiplicand left and multiplier right; counter++. After WIDTH iterations, register the low WIDTH bits -> DONE.
  - DONE: `done`=1 -> IDLE.
- `go` pulses outside IDLE are dropped, not queued.
- Flags, updated only on result write:
  - Z: result==0.
  - N: result[WIDTH-1].
  - C: ADD carry-out; SUB borrow (A_s<B_s unsigned); MUL upper product half ≠0; 0 for all other ops.
  - V: signed overflow for ADD/SUB; 0 for all other ops.
  - ERR: 0, except MUL with multiplier compiled out.
- Shift amounts ≥ WIDTH are impossible because only SHW bits are used.

## Timing
- Reset: entry, A, B, snapshots, result, all flags, accumulator, counter, sync/prev flops = 0; state IDLE; `busy`=0, `done`=0. `disp` follows the registers, so it reads 0.
- Reset mid-operation aborts in the same edge; no `done` is issued.
- Button latency: raw rise sampled at edge k -> pulse high for the cycle after edge k -> effect registered at edge k+1.
- Non-MUL: pulse cycle (IDLE) -> EXEC (busy=1) -> DONE (busy=0, done=1, result valid). `done` is high 2 cycles after the pulse cycle.
- MUL: IDLE -> EXEC -> WIDTH cycles MUL -> DONE. `done` is high WIDTH+2 cycles after the pulse cycle.
- `busy` is high in EXEC and MUL only. `result` and flags hold until the next DONE.

## Configuration
- `ALU_MUL_EN` defined: MUL state, accumulator and counter are built; op 111 behaves as above.
- Not defined: no multiplier hardware. Op 111 follows the single-cycle path: result=0, Z=1, N=C=V=0, ERR=1, `done` 2 cycles after pulse.

## Test plan
- Entry: WIDTH=16, dir=0, press 1,0,1,1 -> entry=0x000B. Then dir=1, press 1 -> entry=0x8005. Same-cycle bit0+bit1 -> exactly one 1 shifted.
- Load/display: entry=0x1234, load_a held -> A=0x1234; disp_sel=01 -> disp=0x1234. load_a+load_b together -> B unchanged.
- ADD: A=0xFFFF, B=0x0001, go -> result=0x0000, Z=1, C=1, V=0, done at pulse+2. SUB: A=0x8000, B=0x0001 -> 0x7FFF, V=1, C=0.
- Shifts: A=0x0F0F, B=0x0004, SHL -> 0xF0F0; SHR -> 0x00F0.
- MUL (ALU_MUL_EN): A=0x0300, B=0x0100 -> result=0x0000, C=1, Z=1, done at pulse+18. A=7, B=6 -> 0x002A. Second go while busy is ignored. Without macro: ERR=1, result=0.
- Reset mid-MUL at cycle 5: busy=0, result=0, no done pulse. Next go runs normally.
